// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential execute unit.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Place individual flag bits at their architectural positions.
    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/sign_ext.sv
// Combinational two's-complement sign extender, IN_W bits up to OUT_W bits.
module sign_ext #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);

    // Equal widths need a plain pass-through: a zero-width replication is illegal.
    if (OUT_W == IN_W) begin : g_pass
        assign o_out = i_in;
    end else begin : g_ext
        assign o_out = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};
    end

endmodule

// File: rtl/alu_seq_ext.sv
// Registered execute unit: single-cycle ALU ops plus a shift-add multiply,
// with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | ready for a new op (subject to output backpressure)
// MUL   | iterating one multiplier bit per cycle
module alu_seq_ext
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_flags;
    logic [WIDTH-1:0]     r_ma;
    logic [WIDTH-1:0]     r_mb;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;

    op_t                  w_op;
    logic [WIDTH-1:0]     w_imm_ext;
    logic [WIDTH-1:0]     w_opb;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_c;
    logic                 w_v;
    logic [3:0]           w_alu_flags;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_accept;
    logic                 w_ld_alu;
    logic                 w_ld_mul;
    logic                 w_mul_done;

    sign_ext #(.IN_W(IMM_W), .OUT_W(WIDTH)) u_sign_ext (
        .i_in  (imm),
        .o_out (w_imm_ext)
    );

    assign w_op     = op_t'(op);
    assign w_opb    = use_imm ? w_imm_ext : b;
    assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Extra top bit carries the ADD carry-out / SUB borrow.
    assign w_sum  = {1'b0, a} + {1'b0, w_opb};
    assign w_diff = {1'b0, a} - {1'b0, w_opb};

    // One shift-add step: add A shifted to the current multiplier bit position.
    assign w_acc_next = r_mb[r_cnt] ? (r_acc + ({{WIDTH{1'b0}}, r_ma} << r_cnt)) : r_acc;

    // Single-cycle ALU result and flags for the op being presented.
    always_comb begin
        w_alu_res = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_c       = w_sum[WIDTH];
                w_v       = (a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_c       = w_diff[WIDTH];
                w_v       = (a[WIDTH-1] != w_opb[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_alu_res = a & w_opb;
            OP_OR:  w_alu_res = a | w_opb;
            OP_XOR: w_alu_res = a ^ w_opb;
            OP_SLL: w_alu_res = a << w_opb[SH_W-1:0];
            OP_SRA: w_alu_res = $unsigned($signed(a) >>> w_opb[SH_W-1:0]);
            default: w_alu_res = '0;
        endcase
        w_alu_flags = pack_flags(w_v, w_c, w_alu_res[WIDTH-1], (w_alu_res == '0));
    end

    // Next-state and load strobes.
    always_comb begin
        w_state_next = r_state;
        w_ld_alu     = 1'b0;
        w_ld_mul     = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_ld_mul     = 1'b1;
                        w_state_next = MUL;
                    end else begin
                        w_ld_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_mul_done   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Result/flag registers, output handshake and multiply iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;

            if (w_ld_alu) begin
                r_result    <= w_alu_res;
                r_flags     <= w_alu_flags;
                r_out_valid <= 1'b1;
            end

            if (w_ld_mul) begin
                r_ma  <= a;
                r_mb  <= w_opb;
                r_acc <= '0;
                r_cnt <= '0;
            end

            if (r_state == MUL) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_mul_done) begin
                    r_cnt       <= '0;
                    r_result    <= w_acc_next[WIDTH-1:0];
                    r_flags     <= pack_flags(|w_acc_next[2*WIDTH-1:WIDTH], 1'b0,
                                              w_acc_next[WIDTH-1],
                                              (w_acc_next[WIDTH-1:0] == '0));
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq_ext.sv
// Bench for alu_seq_ext at WIDTH=8, IMM_W=5: arithmetic reference model with an
// expectation queue checked on every output transfer, plus literal spot checks.
module tb_alu_seq_ext;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] imm;
    logic       use_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expectation queue: written by the driver, consumed by the monitor.
    logic [7:0] e_res [256];
    logic [3:0] e_flg [256];
    int         e_lat [256];
    int         e_acc [256];
    int         wr_idx = 0;
    int         rd_idx = 0;

    alu_seq_ext #(.WIDTH(8), .IMM_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .use_imm   (use_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: returns {V, C, N, Z, result[7:0]} from plain integer arithmetic.
    function automatic logic [11:0] model(input int o, input int av, input int bv);
        int   r;
        int   sa;
        int   sb;
        logic c;
        logic v;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            0: begin r = av + bv; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = av - bv; c = (av < bv); v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = av << (bv % 8);
            6: r = sa >>> (bv % 8);
            default: begin r = av * bv; v = (r > 255); end
        endcase
        r = r & 255;
        return {v, c, r[7], (r == 0), r[7:0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one op; returns after the accepting edge. Records the model expectation.
    // Latency is counted in edges from the accepting edge to the edge raising out_valid.
    task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [4:0] im, input logic ui, output int stalls);
        logic [7:0]  beff;
        logic [11:0] m;
        stalls = 0;
        @(negedge clk);
        op = o; a = av; b = bv; imm = im; use_imm = ui; in_valid = 1'b1;
        #1;
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 50) begin
            check("accept_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            beff = ui ? {{3{im[4]}}, im} : bv;
            m    = model(int'(o), int'(av), int'(beff));
            e_res[wr_idx] = m[7:0];
            e_flg[wr_idx] = m[11:8];
            e_lat[wr_idx] = (o == 3'd7) ? 8 : 0;
            e_acc[wr_idx] = cyc + 1;
            wr_idx++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Wait for a result, pin it against a hand-computed literal, then consume it.
    task automatic expect_out(input string name, input int res, input int flg);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, " valid"}, int'(out_valid), 1);
        check({name, " result"}, int'(result), res);
        check({name, " flags"}, int'(flags), flg);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Count busy cycles after a MUL acceptance; optionally scramble the inputs meanwhile.
    task automatic mul_wait(input string name, input logic scramble);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        @(negedge clk);
        #1;
        while (!out_valid && n < 50) begin
            if (in_ready) bad++;
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
                imm = 5'($urandom); use_imm = 1'($urandom);
            end
            n++;
            @(negedge clk);
            #1;
        end
        check({name, " in_ready_low"}, bad, 0);
        check({name, " busy_cycles"}, n, 8);
    endtask

    // Compare every delivered result against the model, including latency and hold.
    task automatic monitor();
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                rd_idx = wr_idx;
                seen   = 1'b0;
            end else if (out_valid) begin
                if (rd_idx == wr_idx) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("mon result", int'(result), int'(e_res[rd_idx]));
                    check("mon flags", int'(flags), int'(e_flg[rd_idx]));
                    if (!seen) check("mon latency", cyc - e_acc[rd_idx], e_lat[rd_idx]);
                    seen = 1'b1;
                    if (out_ready) begin
                        rd_idx++;
                        seen = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot;
        int bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; imm = '0; use_imm = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset result", int'(result), 0);
        check("reset flags", int'(flags), 0);
        check("reset in_ready", int'(in_ready), 1);

        // ADD
        send(3'd0, 8'h6D, 8'h0C, 5'd0, 1'b0, st);
        expect_out("add1", 'h79, 'b0000);
        send(3'd0, 8'h7F, 8'h01, 5'd0, 1'b0, st);
        expect_out("add_ovf", 'h80, 'b1010);

        // SUB with immediate: B = 0xF6
        send(3'd1, 8'h21, 8'h00, 5'b10110, 1'b1, st);
        expect_out("sub_imm", 'h2B, 'b0100);

        // MUL latency
        send(3'd7, 8'h0D, 8'h0B, 5'd0, 1'b0, st);
        mul_wait("mul1", 1'b0);
        expect_out("mul1", 'h8F, 'b0010);
        send(3'd7, 8'h20, 8'h10, 5'd0, 1'b0, st);
        mul_wait("mul2", 1'b0);
        expect_out("mul2", 'h00, 'b1001);

        // Shifts
        send(3'd6, 8'h90, 8'h02, 5'd0, 1'b0, st);
        expect_out("sra", 'hE4, 'b0010);
        send(3'd5, 8'h90, 8'h02, 5'd0, 1'b0, st);
        expect_out("sll", 'h40, 'b0000);

        // Backpressure, then simultaneous out- and in-transfer
        send(3'd0, 8'h11, 8'h22, 5'd0, 1'b0, st);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (!out_valid || result != 8'h33 || flags != 4'b0000 || in_ready) bad++;
        end
        check("backpressure hold", bad, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(3'd4, 8'hF0, 8'hFF, 5'd0, 1'b0, st);
        check("overlap stalls", st, 0);
        check("overlap new result", int'(result), 'h0F);
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Full-throughput stream of non-MUL ops
        out_ready = 1'b1;
        tot = 0;
        send(3'd2, 8'hCC, 8'hAA, 5'd0, 1'b0, st);     tot += st;
        send(3'd3, 8'h0C, 8'h30, 5'd0, 1'b0, st);     tot += st;
        send(3'd1, 8'h80, 8'h01, 5'd0, 1'b0, st);     tot += st;
        send(3'd0, 8'hFF, 8'h01, 5'd0, 1'b0, st);     tot += st;
        send(3'd5, 8'h01, 8'h00, 5'b10111, 1'b1, st); tot += st;
        send(3'd6, 8'h80, 8'h00, 5'b10111, 1'b1, st); tot += st;
        send(3'd4, 8'h5A, 8'h5A, 5'd0, 1'b0, st);     tot += st;
        send(3'd0, 8'h12, 8'h00, 5'b01111, 1'b1, st); tot += st;
        check("stream stalls", tot, 0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;

        // MUL with negative immediate (B = 0xFF), upper product nonzero
        send(3'd7, 8'h03, 8'h00, 5'b11111, 1'b1, st);
        mul_wait("mul_imm", 1'b0);
        expect_out("mul_imm", 'hFD, 'b1010);

        // Reset three cycles into a MUL
        send(3'd7, 8'h55, 8'h33, 5'd0, 1'b0, st);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort out_valid", int'(out_valid), 0);
        check("abort result", int'(result), 0);
        check("abort in_ready", int'(in_ready), 1);
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (out_valid) bad++;
        end
        check("abort no stale result", bad, 0);

        // Inputs scrambled during the multiply must not matter
        send(3'd7, 8'h0F, 8'h0F, 5'd0, 1'b0, st);
        mul_wait("mul_scr", 1'b1);
        expect_out("mul_scr", 'hE1, 'b0010);

        repeat (3) @(negedge clk);
        #5;
        check("all results delivered", rd_idx, wr_idx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
